// File: rtl/demux_1x4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_1x4 : 1-to-4 registered demultiplexer with valid strobe; non-selected
//             outputs carry {WIDTH{IDLE_VAL}}. DEMUX_1X4_COMB_EN = zero-latency.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module demux_1x4 #(
    parameter int WIDTH    = 1,
    parameter bit IDLE_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] f,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             vld
);

    localparam logic [WIDTH-1:0] IDLE_FILL = {WIDTH{IDLE_VAL}};

    logic [3:0][WIDTH-1:0] route_w;

    always_comb begin
        route_w = {4{IDLE_FILL}};
        if (en) begin
            route_w[sel] = f;
        end
    end

`ifdef DEMUX_1X4_COMB_EN
    logic w_unused;
    assign w_unused = clk ^ rst;

    assign a   = route_w[0];
    assign b   = route_w[1];
    assign c   = route_w[2];
    assign d   = route_w[3];
    assign vld = en;
`else
    logic [3:0][WIDTH-1:0] data_q, data_d;
    logic                  vld_q,  vld_d;

    // A disabled cycle holds the channels but drops the strobe.
    always_comb begin
        data_d = data_q;
        vld_d  = 1'b0;
        if (en) begin
            data_d = route_w;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= {4{IDLE_FILL}};
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign a   = data_q[0];
    assign b   = data_q[1];
    assign c   = data_q[2];
    assign d   = data_q[3];
    assign vld = vld_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4.sv
`default_nettype none
// tb_demux_1x4 : vector table, corner sequences and random traffic against a
//                rule-based model, for a 1-bit/idle-0 and an 8-bit/idle-1 instance.
`timescale 1ns/1ps
module tb_demux_1x4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       f1  = 1'b0;
    logic [7:0] f8  = 8'h00;

    logic       a1, b1, c1, d1, v1;
    logic [7:0] a8, b8, c8, d8;
    logic       v8;

    demux_1x4 #(.WIDTH(1), .IDLE_VAL(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .f(f1), .sel(sel),
        .a(a1), .b(b1), .c(c1), .d(d1), .vld(v1)
    );

    demux_1x4 #(.WIDTH(8), .IDLE_VAL(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .f(f8), .sel(sel),
        .a(a8), .b(b8), .c(c8), .d(d8), .vld(v8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic       m1 [4];
    logic [7:0] m8 [4];
    logic       mv;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected channel contents after an edge, from the routing rules.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m1[i] = 1'b0;
                m8[i] = 8'hFF;
            end
            mv = 1'b0;
        end else if (en) begin
            for (int i = 0; i < 4; i++) begin
                m1[i] = (i == int'(sel)) ? f1 : 1'b0;
                m8[i] = (i == int'(sel)) ? f8 : 8'hFF;
            end
            mv = 1'b1;
        end else begin
            mv = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_w1"}, {59'd0, d1, c1, b1, a1, v1},
              {59'd0, m1[3], m1[2], m1[1], m1[0], mv});
        check({tag, "_w8"}, {31'd0, d8, c8, b8, a8, v8},
              {31'd0, m8[3], m8[2], m8[1], m8[0], mv});
    endtask

`ifndef DEMUX_1X4_COMB_EN
    task automatic cycle(input logic r, input logic e, input logic [1:0] s,
                         input logic fa, input logic [7:0] fb);
        rst = r; en = e; sel = s; f1 = fa; f8 = fb;
        @(posedge clk);
        model_edge();
        #1;
        check_model("model");
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic [1:0] s;
        logic       f;
        logic [7:0] fb;
        logic [3:0] exp_dcba;
        logic       exp_vld;
    } vec_t;

    vec_t vecs [15];

    initial begin
        for (int i = 0; i < 4; i++) begin
            m1[i] = 1'b0;
            m8[i] = 8'hFF;
        end
        mv = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 2'd2, 1'b1, 8'hA5, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd2, 1'b1, 8'hA5, 4'b0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h01, 4'b0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h02, 4'b0000, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 8'h03, 4'b0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 1'b0, 8'h04, 4'b0000, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h05, 4'b0001, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b1, 8'h06, 4'b0010, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b1, 8'h07, 4'b0100, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2'd3, 1'b1, 8'h08, 4'b1000, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 1'b1, 8'h3C, 4'b1000, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1000, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b1000, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'd1, 1'b1, 8'h5A, 4'b0010, 1'b1};

        #2;
        for (int k = 0; k < 15; k++) begin
            cycle(vecs[k].r, vecs[k].e, vecs[k].s, vecs[k].f, vecs[k].fb);
            check($sformatf("vec%0d", k), {59'd0, d1, c1, b1, a1, v1},
                  {59'd0, vecs[k].exp_dcba, vecs[k].exp_vld});
        end

        // Idle fill of ones on the wide instance after the last vector.
        check("fill_w8", {24'd0, a8, b8, c8, d8, 7'd0, v8},
              {24'd0, 8'hFF, 8'h5A, 8'hFF, 8'hFF, 7'd0, 1'b1});

        // Reset arriving mid-stream discards the capture in flight.
        cycle(1'b0, 1'b1, 2'd0, 1'b1, 8'h11);
        cycle(1'b0, 1'b1, 2'd1, 1'b1, 8'h22);
        cycle(1'b1, 1'b1, 2'd2, 1'b1, 8'h33);
        check("midrst_w1", {59'd0, d1, c1, b1, a1, v1}, 64'd0);
        check("midrst_w8", {24'd0, a8, b8, c8, d8, 7'd0, v8},
              {24'd0, 32'hFFFF_FFFF, 8'd0});
        cycle(1'b0, 1'b1, 2'd0, 1'b1, 8'h44);
        check("post_rst_a", {55'd0, a8, a1}, {55'd0, 8'h44, 1'b1});

        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom),
                  1'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
`else
    task automatic apply(input logic e, input logic [1:0] s,
                         input logic fa, input logic [7:0] fb);
        en = e; sel = s; f1 = fa; f8 = fb; rst = 1'($urandom);
        #1;
        for (int i = 0; i < 4; i++) begin
            m1[i] = (e && i == int'(s)) ? fa : 1'b0;
            m8[i] = (e && i == int'(s)) ? fb : 8'hFF;
        end
        mv = e;
        check_model("comb");
    endtask

    initial begin
        apply(1'b1, 2'd2, 1'b1, 8'h5A);
        check("comb_c", {59'd0, d1, c1, b1, a1, v1}, {59'd0, 4'b0100, 1'b1});
        apply(1'b0, 2'd2, 1'b1, 8'h5A);
        check("comb_off", {59'd0, d1, c1, b1, a1, v1}, 64'd0);
        for (int k = 0; k < 50; k++) begin
            apply(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
`endif

endmodule
`default_nettype wire
